wb_queue: RTL and testbench

Parametrised write-back stage for the MIPS pipeline. Accepts retiring instructions from the MEM stage and selects their result from the ALU, load data, or the link address (PC + increment). Holds them in an in-order queue of depth DEPTH so that late load data can return over a valid-only response port. Drives a registered register-file write port one entry per cycle and reports pending-destination hazards to decode.

---
 rtl/wb_queue_if.sv | 34 +++
 rtl/wb_queue.sv | 103 ++++++++++
 tb/tb_wb_queue.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_queue_if.sv
// wb_queue_if: bundles the wb_queue MEM-stage handshake, load-response port,
// register-file write port, hazard query and status outputs.
// master: the pipeline side (drives instructions, load beats, hazard address).
// slave:  the write-back queue (drives in_ready, rf_*, hz_hit, occ, err_spurious).
interface wb_queue_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 4
);
    localparam int OW = $clog2(DEPTH) + 1;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_sel;
    logic [REG_AW-1:0] in_dest;
    logic [DATA_W-1:0] alu_in;
    logic [DATA_W-1:0] pc_in;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [REG_AW-1:0] hz_addr;
    logic              hz_hit;
    logic [OW-1:0]     occ;
    logic              err_spurious;
    modport master (
        output in_valid, in_sel, in_dest, alu_in, pc_in, mem_rvalid, mem_rdata, hz_addr,
        input  in_ready, rf_we, rf_waddr, rf_wdata, hz_hit, occ, err_spurious
    );
    modport slave (
        input  in_valid, in_sel, in_dest, alu_in, pc_in, mem_rvalid, mem_rdata, hz_addr,
        output in_ready, rf_we, rf_waddr, rf_wdata, hz_hit, occ, err_spurious
    );
endinterface

// File: rtl/wb_queue.sv
// wb_queue: in-order MIPS write-back queue selecting ALU / load / link results.
// Ports: clk (rising edge), rst (asynchronous, active-high),
//        q (wb_queue_if.slave): in_valid/in_ready/in_sel/in_dest/alu_in/pc_in from MEM,
//        mem_rvalid/mem_rdata load beats (program order), registered rf_we/rf_waddr/rf_wdata,
//        hz_addr/hz_hit pending-write query, occ entry count, sticky err_spurious.
// Optional: define WB_BYPASS_EN to let a non-MEM entry arriving at an empty queue
//           load the register-file write port directly (one cycle sooner).
module wb_queue #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 4,
    parameter int LINK_INC = 1
) (
    input logic       clk,
    input logic       rst,
    wb_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    logic [REG_AW-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  mem_q, done_q;
    logic [PW-1:0]     head_q, tail_q, fill_idx;
    logic [OW-1:0]     occ_q;
    logic              rf_we_q, err_q, fill_hit, q_hit;
    logic [REG_AW-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q, in_data;
    logic              accept, is_mem, retire, byp, enq;
    assign q.in_ready     = occ_q != OW'(DEPTH);
    assign q.occ          = occ_q;
    assign q.rf_we        = rf_we_q;
    assign q.rf_waddr     = rf_waddr_q;
    assign q.rf_wdata     = rf_wdata_q;
    assign q.err_spurious = err_q;
    assign accept  = q.in_valid && q.in_ready;
    assign is_mem  = q.in_sel == 2'b01;
    assign in_data = q.in_sel == 2'b10 ? q.pc_in + DATA_W'(LINK_INC) : q.alu_in;
    assign retire  = occ_q != '0 && done_q[head_q];
`ifdef WB_BYPASS_EN
    // An empty queue cannot retire, so the output registers are free for the new entry.
    assign byp = accept && !is_mem && occ_q == '0;
`else
    assign byp = 1'b0;
`endif
    assign enq = accept && !byp;
    // Oldest valid load still waiting for data; beats arrive in program order.
    always_comb begin
        fill_hit = 1'b0;
        fill_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (!fill_hit && OW'(i) < occ_q && mem_q[head_q + PW'(i)] && !done_q[head_q + PW'(i)]) begin
                fill_hit = 1'b1;
                fill_idx = head_q + PW'(i);
            end
        end
    end
    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (OW'(i) < occ_q && dest_q[head_q + PW'(i)] == q.hz_addr) q_hit = 1'b1;
        end
    end
    assign q.hz_hit = q.hz_addr != '0 && (q_hit || (rf_we_q && rf_waddr_q == q.hz_addr));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            mem_q      <= '0;
            done_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (enq) begin
                mem_q[tail_q]  <= is_mem;
                done_q[tail_q] <= !is_mem;
                tail_q         <= tail_q + 1'b1;
            end
            if (q.mem_rvalid && fill_hit) done_q[fill_idx] <= 1'b1;
            if (q.mem_rvalid && !fill_hit) err_q <= 1'b1;
            if (retire) head_q <= head_q + 1'b1;
            occ_q   <= occ_q + OW'(enq) - OW'(retire);
            rf_we_q <= retire ? dest_q[head_q] != '0 : byp && q.in_dest != '0;
            if (retire) begin
                rf_waddr_q <= dest_q[head_q];
                rf_wdata_q <= data_q[head_q];
            end else if (byp) begin
                rf_waddr_q <= q.in_dest;
                rf_wdata_q <= in_data;
            end
        end
    end
    // Payload storage needs no reset: validity is tracked by occ/head.
    always_ff @(posedge clk) begin
        if (enq) begin
            dest_q[tail_q] <= q.in_dest;
            data_q[tail_q] <= in_data;
        end
        if (q.mem_rvalid && fill_hit) data_q[fill_idx] <= q.mem_rdata;
    end
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: self-checking bench for wb_queue (directed scenarios plus a
// randomized run compared against a program-order reference model).
module tb_wb_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    wb_queue_if #(.DATA_W(32), .REG_AW(5), .DEPTH(4)) bus ();
    wb_queue #(.DATA_W(32), .REG_AW(5), .DEPTH(4), .LINK_INC(1)) dut (.clk(clk), .rst(rst), .q(bus));
    int passed = 0;
    int total  = 0;
    typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;
    typedef struct {logic [4:0] dest; logic [31:0] data; bit is_mem;} ent_t;
    wr_t got[$];
    always @(negedge clk) if (!rst && bus.rf_we) got.push_back('{bus.rf_waddr, bus.rf_wdata});
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic idle;
        bus.in_valid = 0; bus.in_sel = 0; bus.in_dest = 0; bus.alu_in = 0; bus.pc_in = 0;
        bus.mem_rvalid = 0; bus.mem_rdata = 0;
    endtask
    task automatic drive(input logic [1:0] sel, input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc);
        bus.in_valid = 1; bus.in_sel = sel; bus.in_dest = dest; bus.alu_in = alu; bus.pc_in = pc;
    endtask
    task automatic test_reset;
        idle();
        bus.hz_addr = 5;
        rst = 1;
        step(); step();
        total++; if (bus.rf_we !== 1'b0) $display("FAIL reset_rf_we got %0b exp 0", bus.rf_we); else passed++;
        total++; if (bus.rf_waddr !== 5'd0) $display("FAIL reset_rf_waddr got %0d exp 0", bus.rf_waddr); else passed++;
        total++; if (bus.rf_wdata !== 32'd0) $display("FAIL reset_rf_wdata got %h exp 0", bus.rf_wdata); else passed++;
        total++; if (bus.occ !== 3'd0) $display("FAIL reset_occ got %0d exp 0", bus.occ); else passed++;
        total++; if (bus.err_spurious !== 1'b0) $display("FAIL reset_err got %0b exp 0", bus.err_spurious); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); else passed++;
        total++; if (bus.hz_hit !== 1'b0) $display("FAIL reset_hz_hit got %0b exp 0", bus.hz_hit); else passed++;
        rst = 0;
        step();
    endtask
    task automatic test_alu_latency;
        logic e2, e3;
`ifdef WB_BYPASS_EN
        e2 = 1; e3 = 0;
`else
        e2 = 0; e3 = 1;
`endif
        drive(2'b00, 5'd3, 32'h1234, 32'h0);
        step();
        bus.in_valid = 0;
        total++; if (bus.rf_we !== e2) $display("FAIL alu_we_c2 got %0b exp %0b", bus.rf_we, e2); else passed++;
        step();
        total++; if (bus.rf_we !== e3) $display("FAIL alu_we_c3 got %0b exp %0b", bus.rf_we, e3); else passed++;
        total++; if (bus.rf_waddr !== 5'd3) $display("FAIL alu_waddr got %0d exp 3", bus.rf_waddr); else passed++;
        total++; if (bus.rf_wdata !== 32'h1234) $display("FAIL alu_wdata got %h exp 1234", bus.rf_wdata); else passed++;
        step();
        total++; if (bus.rf_we !== 1'b0) $display("FAIL alu_we_c4 got %0b exp 0", bus.rf_we); else passed++;
        total++; if (bus.occ !== 3'd0) $display("FAIL alu_occ got %0d exp 0", bus.occ); else passed++;
    endtask
    task automatic test_link_wrap;
        got.delete();
        drive(2'b10, 5'd31, 32'h5555, 32'hFFFF_FFFF);
        step();
        bus.in_valid = 0;
        for (int i = 0; i < 6 && got.size() == 0; i++) step();
        step();
        total++; if (got.size() != 1) $display("FAIL link_count got %0d exp 1", got.size()); else passed++;
        if (got.size() >= 1) begin
            total++; if (got[0].a !== 5'd31) $display("FAIL link_waddr got %0d exp 31", got[0].a); else passed++;
            total++; if (got[0].d !== 32'h0) $display("FAIL link_wdata got %h exp 0", got[0].d); else passed++;
        end
    endtask
    task automatic test_mem_order;
        bus.hz_addr = 6;
        drive(2'b01, 5'd5, 32'h0, 32'h0);
        step();
        drive(2'b00, 5'd6, 32'h66, 32'h0);
        step();
        bus.in_valid = 0;
        total++; if (bus.hz_hit !== 1'b1) $display("FAIL mo_hz_queued got %0b exp 1", bus.hz_hit); else passed++;
        step();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hAA;
        step();
        bus.mem_rvalid = 0;
        total++; if (bus.rf_we !== 1'b0) $display("FAIL mo_we_early got %0b exp 0", bus.rf_we); else passed++;
        total++; if (bus.hz_hit !== 1'b1) $display("FAIL mo_hz_wait got %0b exp 1", bus.hz_hit); else passed++;
        step();
        total++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'hAA})
            $display("FAIL mo_first got we=%0b a=%0d d=%h exp we=1 a=5 d=aa", bus.rf_we, bus.rf_waddr, bus.rf_wdata); else passed++;
        total++; if (bus.hz_hit !== 1'b1) $display("FAIL mo_hz_first got %0b exp 1", bus.hz_hit); else passed++;
        step();
        total++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd6, 32'h66})
            $display("FAIL mo_second got we=%0b a=%0d d=%h exp we=1 a=6 d=66", bus.rf_we, bus.rf_waddr, bus.rf_wdata); else passed++;
        step();
        total++; if (bus.hz_hit !== 1'b0) $display("FAIL mo_hz_after got %0b exp 0", bus.hz_hit); else passed++;
        total++; if (bus.occ !== 3'd0) $display("FAIL mo_occ got %0d exp 0", bus.occ); else passed++;
    endtask
    task automatic test_full;
        got.delete();
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 5'(8 + k), 32'h0, 32'h0);
            step();
        end
        bus.in_valid = 0;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL full_ready got %0b exp 0", bus.in_ready); else passed++;
        total++; if (bus.occ !== 3'd4) $display("FAIL full_occ got %0d exp 4", bus.occ); else passed++;
        drive(2'b00, 5'd12, 32'hBAD, 32'h0);
        step();
        bus.in_valid = 0;
        total++; if (bus.occ !== 3'd4) $display("FAIL full_reject_occ got %0d exp 4", bus.occ); else passed++;
        for (int k = 0; k < 4; k++) begin
            bus.mem_rvalid = 1; bus.mem_rdata = 32'h100 + k;
            step();
        end
        bus.mem_rvalid = 0;
        repeat (6) step();
        total++; if (got.size() != 4) $display("FAIL full_count got %0d exp 4", got.size()); else passed++;
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            total++;
            if (got[k].a !== 5'(8 + k) || got[k].d !== 32'h100 + k)
                $display("FAIL full_write%0d got a=%0d d=%h exp a=%0d d=%h", k, got[k].a, got[k].d, 8 + k, 32'h100 + k);
            else passed++;
        end
        total++; if (bus.occ !== 3'd0) $display("FAIL full_drain_occ got %0d exp 0", bus.occ); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL full_drain_ready got %0b exp 1", bus.in_ready); else passed++;
    endtask
    task automatic test_dest0;
        got.delete();
        bus.hz_addr = 0;
        drive(2'b00, 5'd0, 32'h7, 32'h0);
        step();
        bus.in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.hz_hit !== 1'b0) $display("FAIL d0_hz%0d got %0b exp 0", i, bus.hz_hit); else passed++;
            step();
        end
        total++; if (bus.occ !== 3'd0) $display("FAIL d0_occ got %0d exp 0", bus.occ); else passed++;
        total++; if (got.size() != 0) $display("FAIL d0_writes got %0d exp 0", got.size()); else passed++;
    endtask
    task automatic test_random;
        ent_t prog[$];
        wr_t exp[$];
        ent_t e;
        int fill_ptr = 0;
        int ld_enq = 0;
        int ld_fill = 0;
        got.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            int new_ld = 0;
            drive(2'($urandom_range(0, 3)), 5'($urandom), $urandom, $urandom);
            bus.in_valid = $urandom_range(0, 2) != 0;
            bus.hz_addr = 5'($urandom);
            if (bus.in_valid && bus.in_ready) begin
                e.dest = bus.in_dest;
                e.is_mem = bus.in_sel == 2'b01;
                e.data = bus.in_sel == 2'b10 ? bus.pc_in + 32'd1 : bus.alu_in;
                prog.push_back(e);
                new_ld = e.is_mem ? 1 : 0;
            end
            bus.mem_rvalid = ld_fill < ld_enq && $urandom_range(0, 2) == 0;
            if (bus.mem_rvalid) begin
                bus.mem_rdata = $urandom;
                while (!prog[fill_ptr].is_mem) fill_ptr++;
                e = prog[fill_ptr];
                e.data = bus.mem_rdata;
                prog[fill_ptr] = e;
                fill_ptr++;
                ld_fill++;
            end
            step();
            ld_enq += new_ld;
        end
        bus.in_valid = 0;
        while (ld_fill < ld_enq) begin
            bus.mem_rvalid = 1;
            bus.mem_rdata = $urandom;
            while (!prog[fill_ptr].is_mem) fill_ptr++;
            e = prog[fill_ptr];
            e.data = bus.mem_rdata;
            prog[fill_ptr] = e;
            fill_ptr++;
            ld_fill++;
            step();
        end
        bus.mem_rvalid = 0;
        repeat (8) step();
        foreach (prog[i]) if (prog[i].dest != 0) exp.push_back('{prog[i].dest, prog[i].data});
        total++; if (got.size() != exp.size()) $display("FAIL rnd_count got %0d exp %0d", got.size(), exp.size()); else passed++;
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++;
            if (got[i].a !== exp[i].a || got[i].d !== exp[i].d)
                $display("FAIL rnd_write%0d got a=%0d d=%h exp a=%0d d=%h", i, got[i].a, got[i].d, exp[i].a, exp[i].d);
            else passed++;
        end
        total++; if (bus.occ !== 3'd0) $display("FAIL rnd_occ got %0d exp 0", bus.occ); else passed++;
        total++; if (bus.err_spurious !== 1'b0) $display("FAIL rnd_err got %0b exp 0", bus.err_spurious); else passed++;
    endtask
    task automatic test_spurious;
        got.delete();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEAD;
        step();
        bus.mem_rvalid = 0;
        total++; if (bus.err_spurious !== 1'b1) $display("FAIL sp_err got %0b exp 1", bus.err_spurious); else passed++;
        repeat (3) step();
        total++; if (bus.err_spurious !== 1'b1) $display("FAIL sp_sticky got %0b exp 1", bus.err_spurious); else passed++;
        total++; if (got.size() != 0) $display("FAIL sp_writes got %0d exp 0", got.size()); else passed++;
    endtask
    task automatic test_reset_mid;
        drive(2'b01, 5'd9, 32'h0, 32'h0);
        step();
        bus.in_valid = 0;
        total++; if (bus.occ !== 3'd1) $display("FAIL rm_occ_before got %0d exp 1", bus.occ); else passed++;
        rst = 1;
        #1;
        total++; if (bus.occ !== 3'd0) $display("FAIL rm_occ got %0d exp 0", bus.occ); else passed++;
        total++; if (bus.err_spurious !== 1'b0) $display("FAIL rm_err_clr got %0b exp 0", bus.err_spurious); else passed++;
        step();
        rst = 0;
        step();
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h77;
        step();
        bus.mem_rvalid = 0;
        total++; if (bus.err_spurious !== 1'b1) $display("FAIL rm_late_beat got %0b exp 1", bus.err_spurious); else passed++;
    endtask
    initial begin
        test_reset();
        test_alu_latency();
        test_link_wrap();
        test_mem_order();
        test_full();
        test_dest0();
        test_random();
        test_spurious();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
